// File: rtl/xs3_bcd_accumulator.sv
// xs3_bcd_accumulator
// Accepts one Excess-3 coded decimal digit at a time and adds it into a
// two-digit BCD running total. Each digit walks through a five-state
// pipeline (IDLE, DECODE, ADD, ADJUST, RESP), so only one digit is in flight.
// The total is written back only on the ADJUST->RESP edge.
// SATURATE=0 wraps the total from 99 to 00. SATURATE=1 pins the total at 99.
// ovf and err are sticky until clear or reset.
module xs3_bcd_accumulator #(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_xs3,
  output logic       in_ready,
  input  logic       clear,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_ones,
  output logic       out_valid,
  output logic       ovf,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ADD    = 3'd2,
    ADJUST = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        started_reg;    // low during reset, high from the first edge after it
  logic [3:0]  code_reg;       // captured Excess-3 code
  logic [3:0]  digit_reg;      // decoded BCD digit
  logic        bad_reg;        // captured code was not a legal Excess-3 digit
  logic [4:0]  ones_tmp_reg;   // ones digit plus incoming digit, 0..18
  logic [3:0]  sum_tens_reg;
  logic [3:0]  sum_ones_reg;
  logic        ovf_reg;
  logic        err_reg;

  logic        accept;
  logic        code_bad;
  logic        carry;
  logic [3:0]  ones_adj;
  logic [3:0]  tens_adj;
  logic        wrap_ovf;

  // A clear in IDLE takes priority over a digit offered in the same cycle
  assign accept   = in_valid && in_ready && !clear;
  assign code_bad = (code_reg < 4'd3) || (code_reg > 4'd12);

  // State register, plus the flag that holds in_ready low until reset is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
    end
  end

  // Next state: clear aborts from anywhere; only IDLE waits for a digit
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = DECODE;
        DECODE:  state_next = ADD;
        ADD:     state_next = ADJUST;
        ADJUST:  state_next = RESP;
        RESP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; an aborting clear also masks the RESP pulse
  always_comb begin
    in_ready  = started_reg && (state_reg == IDLE);
    out_valid = (state_reg == RESP) && !clear;
  end

  // Decimal adjust of the ones sum and the carry into tens, including overflow
  always_comb begin
    carry    = (ones_tmp_reg > 5'd9);
    // In 4-bit arithmetic, subtracting 10 maps 10..18 onto 0..8 correctly
    ones_adj = carry ? (ones_tmp_reg[3:0] - 4'd10) : ones_tmp_reg[3:0];
    tens_adj = sum_tens_reg;
    wrap_ovf = 1'b0;
    if (carry) begin
      if (sum_tens_reg == 4'd9) begin
        wrap_ovf = 1'b1;
        if (SATURATE) begin
          tens_adj = 4'd9;
          ones_adj = 4'd9;
        end else begin
          tens_adj = 4'd0;
        end
      end else begin
        tens_adj = sum_tens_reg + 4'd1;
      end
    end
  end

  // Datapath: capture on accept, then decode, add, and write back per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg     <= 4'd0;
      digit_reg    <= 4'd0;
      bad_reg      <= 1'b0;
      ones_tmp_reg <= 5'd0;
      sum_tens_reg <= 4'd0;
      sum_ones_reg <= 4'd0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else if (clear) begin
      sum_tens_reg <= 4'd0;
      sum_ones_reg <= 4'd0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (accept) begin
        code_reg <= in_xs3;
      end
      case (state_reg)
        DECODE: begin
          digit_reg <= code_reg - 4'd3;
          bad_reg   <= code_bad;
          if (code_bad) begin
            err_reg <= 1'b1;
          end
        end
        ADD: begin
          ones_tmp_reg <= {1'b0, sum_ones_reg} + {1'b0, digit_reg};
        end
        ADJUST: begin
          // An illegal code leaves the total and ovf untouched
          if (!bad_reg) begin
            sum_tens_reg <= tens_adj;
            sum_ones_reg <= ones_adj;
            if (wrap_ovf) begin
              ovf_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_tens = sum_tens_reg;
  assign sum_ones = sum_ones_reg;
  assign ovf      = ovf_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_xs3_bcd_accumulator.sv
// Bench for xs3_bcd_accumulator: a wrapping and a saturating instance share stimulus.
// Expected totals come from a hand-built vector table. Each accepted digit
// pushes its expectation to a queue; the monitor pops it on out_valid.
module tb_xs3_bcd_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_xs3;
  logic       clear;

  logic       rdy0, ov0, ovf0, err0;
  logic [3:0] t0, o0;
  logic       rdy1, ov1, ovf1, err1;
  logic [3:0] t1, o1;

  xs3_bcd_accumulator #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_xs3(in_xs3),
    .in_ready(rdy0), .clear(clear), .sum_tens(t0), .sum_ones(o0),
    .out_valid(ov0), .ovf(ovf0), .err(err0)
  );

  xs3_bcd_accumulator #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_xs3(in_xs3),
    .in_ready(rdy1), .clear(clear), .sum_tens(t1), .sum_ones(o1),
    .out_valid(ov1), .ovf(ovf1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       clr;
    logic [3:0] code;
    int       t0, o0, t1, o1;
    bit       ovf, err;
  } vec_t;

  typedef struct {
    int t0, o0, t1, o1;
    bit ovf, err;
    int cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic logic [3:0] x3(int d);
    logic [3:0] c;
    c = 4'(d + 3);
    return c;
  endfunction

  function automatic void addv(bit clr, logic [3:0] code, int a0, int b0, int a1, int b1,
                               bit ov, bit er);
    vec_t v;
    v.clr = clr; v.code = code;
    v.t0 = a0; v.o0 = b0; v.t1 = a1; v.o1 = b1;
    v.ovf = ov; v.err = er;
    vecs.push_back(v);
  endfunction

  function automatic exp_t mk(int a0, int b0, int a1, int b1, bit ov, bit er);
    exp_t e;
    e.t0 = a0; e.o0 = b0; e.t1 = a1; e.o1 = b1;
    e.ovf = ov; e.err = er; e.cyc = 0;
    return e;
  endfunction

  // Response monitor: every out_valid must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (ov0 || ov1)) begin
      exp_t e;
      chk("out_valid_pair", int'(ov0 && ov1), 1);
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.cyc, 4);
        chk("wrap_tens", int'(t0), e.t0);
        chk("wrap_ones", int'(o0), e.o0);
        chk("sat_tens", int'(t1), e.t1);
        chk("sat_ones", int'(o1), e.o1);
        chk("wrap_ovf", int'(ovf0), int'(e.ovf));
        chk("sat_ovf", int'(ovf1), int'(e.ovf));
        chk("wrap_err", int'(err0), int'(e.err));
        chk("sat_err", int'(err1), int'(e.err));
        $display("resp cyc=%0d wrap=%0d%0d sat=%0d%0d ovf=%0b/%0b err=%0b/%0b",
                 cyc, t0, o0, t1, o1, ovf0, ovf1, err0, err1);
      end
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_wrap_tens"}, int'(t0), 0);
    chk({nm, "_wrap_ones"}, int'(o0), 0);
    chk({nm, "_sat_tens"}, int'(t1), 0);
    chk({nm, "_sat_ones"}, int'(o1), 0);
    chk({nm, "_ovf"}, int'(ovf0 | ovf1), 0);
    chk({nm, "_err"}, int'(err0 | err1), 0);
    chk({nm, "_out_valid"}, int'(ov0 | ov1), 0);
  endtask

  // Offer a digit until accepted; optionally queue its expected response
  task automatic send(input logic [3:0] code, input bit push, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_xs3   = code;
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      chk("accept_timeout", 0, 1);
    end else begin
      chk("ready_pair", int'(rdy1), 1);
      if (push) begin
        e.cyc = cyc;
        q.push_back(e);
      end
      $display("send cyc=%0d code=%b push=%0b", cyc, code, push);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_xs3   = 4'($urandom_range(0, 15));
  endtask

  // Clear from IDLE with a digit offered at the same time (it must be ignored)
  task automatic do_clear();
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) chk("clear_idle_timeout", 0, 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_xs3   = x3(7);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_zero("clear_idle");
    $display("clear cyc=%0d", cyc);
  endtask

  initial begin
    int n, guard, last;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_xs3 = 4'd0; clear = 1'b0;

    // Vector table: clear-before flag, code, wrap total, sat total, ovf, err
    addv(0, x3(4), 0, 4, 0, 4, 0, 0);
    addv(0, x3(5), 0, 9, 0, 9, 0, 0);
    addv(0, x3(1), 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      addv(k == 1, x3(9), (9 * k) / 10, (9 * k) % 10, (9 * k) / 10, (9 * k) % 10, 0, 0);
    addv(0, x3(5), 9, 5, 9, 5, 0, 0);
    addv(0, x3(5), 0, 0, 9, 9, 1, 0);
    addv(0, x3(7), 0, 7, 9, 9, 1, 0);
    for (int k = 1; k <= 10; k++)
      addv(k == 1, x3(9), (9 * k) / 10, (9 * k) % 10, (9 * k) / 10, (9 * k) % 10, 0, 0);
    addv(0, x3(9), 9, 9, 9, 9, 0, 0);
    addv(0, x3(0), 9, 9, 9, 9, 0, 0);
    addv(0, x3(1), 0, 0, 9, 9, 1, 0);
    addv(1, x3(9), 0, 9, 0, 9, 0, 0);
    addv(0, x3(9), 1, 8, 1, 8, 0, 0);
    addv(0, x3(5), 2, 3, 2, 3, 0, 0);
    addv(0, 4'b1110, 2, 3, 2, 3, 0, 1);
    addv(0, 4'b0011, 2, 3, 2, 3, 0, 1);
    addv(0, 4'b0000, 2, 3, 2, 3, 0, 1);
    addv(0, 4'b1101, 2, 3, 2, 3, 0, 1);

    // Reset state
    #2;
    chk_zero("reset");
    chk("reset_ready", int'(rdy0 | rdy1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", int'(rdy0), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(rdy0), 1);

    // Table-driven accumulation
    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      send(vecs[i].code, 1'b1,
           mk(vecs[i].t0, vecs[i].o0, vecs[i].t1, vecs[i].o1, vecs[i].ovf, vecs[i].err));
    end

    // in_valid held high with 1100: accepts only in IDLE, every 5 cycles
    do_clear();
    in_valid = 1'b1;
    in_xs3   = 4'b1100;
    n = 0; guard = 0; last = 0;
    while (n < 3 && guard < 40) begin
      if (rdy0) begin
        if (n > 0) chk("accept_spacing", cyc - last, 5);
        last = cyc;
        n++;
        e = mk((9 * n) / 10, (9 * n) % 10, (9 * n) / 10, (9 * n) % 10, 0, 0);
        e.cyc = cyc;
        q.push_back(e);
        $display("held accept cyc=%0d n=%0d", cyc, n);
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    chk("held_accepts", n, 3);

    // Build total 42 with err set, then clear in ADD aborts the next digit
    do_clear();
    for (int k = 1; k <= 4; k++)
      send(x3(9), 1'b1, mk((9 * k) / 10, (9 * k) % 10, (9 * k) / 10, (9 * k) % 10, 0, 0));
    send(x3(6), 1'b1, mk(4, 2, 4, 2, 0, 0));
    send(4'b1111, 1'b1, mk(4, 2, 4, 2, 0, 1));
    send(x3(5), 1'b0, mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_zero("clear_add");
    chk("clear_add_ready", int'(rdy0), 1);
    $display("clear in ADD cyc=%0d", cyc);
    repeat (6) @(negedge clk);

    // Nonzero total with err set, then reset pulsed while in DECODE
    send(4'b1111, 1'b1, mk(0, 0, 0, 0, 0, 1));
    send(x3(9), 1'b1, mk(0, 9, 0, 9, 0, 1));
    send(x3(3), 1'b0, mk(0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    chk("async_reset_ready", int'(rdy0), 0);
    $display("reset in DECODE cyc=%0d", cyc);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_ready_before_edge", int'(rdy0), 0);
    @(negedge clk);
    chk("rst2_ready_after_edge", int'(rdy0), 1);
    repeat (6) @(negedge clk);
    chk_zero("post_reset");

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
